spi_cmd_sequencer: RTL and testbench

// - Command-level controller sitting above the byte-wide SPI slave.
// - Parses framed SPI transactions (cmd, addr_hi, addr_lo, data...) into cart-memory read/write requests.
// - Sequences the req/ack handshake to the shared memory port.
// - Loads read data back toward the SPI slave for return on MISO.

---
 rtl/spi_cmd_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_spi_cmd_sequencer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_sequencer.sv
// Command sequencer between a byte-wide SPI slave and the shared cart-memory port.
// Optional ID command (0x9F returns ID_VALUE) is compiled in with `define SPI_CMD_ID_EN.
//
// state   | meaning
// IDLE    | no frame, waiting for cs_n fall
// CMD     | waiting for command byte
// ADDR_HI | waiting for address bits 15:8
// ADDR_LO | waiting for address bits 7:0
// WDATA   | waiting for next write data byte
// WR_REQ  | write request outstanding
// RD_REQ  | read request outstanding
// RD_WAIT | read byte loaded, waiting for master's dummy byte
// ERROR   | bad frame, ignoring bytes until cs_n rises
// ID_HOLD | ID byte returned on every byte (SPI_CMD_ID_EN only)
module spi_cmd_sequencer #(
  parameter int unsigned TIMEOUT = 255
`ifdef SPI_CMD_ID_EN
  , parameter logic [7:0] ID_VALUE = 8'hA5
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cs_n,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  output logic [7:0]  tx_byte,
  output logic        tx_load,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic        busy,
  output logic        err
);

  typedef enum logic [3:0] {
    IDLE, CMD, ADDR_HI, ADDR_LO, WDATA, WR_REQ, RD_REQ, RD_WAIT, ERROR
`ifdef SPI_CMD_ID_EN
    , ID_HOLD
`endif
  } state_t;

  localparam logic [7:0] TCNT_LOAD = TIMEOUT[7:0];

  state_t      state_q, state_d;
  logic        cs_q;
  logic [7:0]  tcnt_q, tcnt_d;
  logic        is_wr_q, is_wr_d;
  logic        abort_q, abort_d;
  logic        req_d, we_d, tx_load_d, err_d;
  logic [15:0] addr_d;
  logic [7:0]  wdata_d, tx_byte_d;
  logic        cs_fall;

  assign cs_fall = cs_q & ~cs_n;
  assign busy    = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cs_q      <= 1'b1;
      tcnt_q    <= '0;
      is_wr_q   <= 1'b0;
      abort_q   <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      tx_byte   <= '0;
      tx_load   <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_q   <= state_d;
      cs_q      <= cs_n;
      tcnt_q    <= tcnt_d;
      is_wr_q   <= is_wr_d;
      abort_q   <= abort_d;
      mem_req   <= req_d;
      mem_we    <= we_d;
      mem_addr  <= addr_d;
      mem_wdata <= wdata_d;
      tx_byte   <= tx_byte_d;
      tx_load   <= tx_load_d;
      err       <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tcnt_d    = tcnt_q;
    is_wr_d   = is_wr_q;
    abort_d   = abort_q;
    req_d     = mem_req;
    we_d      = mem_we;
    addr_d    = mem_addr;
    wdata_d   = mem_wdata;
    tx_byte_d = tx_byte;
    tx_load_d = 1'b0;
    err_d     = err;

    // An outstanding request owns the FSM until ack or timeout, even if cs_n rises.
    if (mem_req) begin
      abort_d = abort_q | cs_n;
      if (rx_valid) err_d = 1'b1;
      if (mem_ack) begin
        req_d  = 1'b0;
        tcnt_d = '0;
        addr_d = mem_addr + 16'd1;
        if (state_q == RD_REQ) begin
          tx_byte_d = mem_rdata;
          tx_load_d = 1'b1;
        end
        if (abort_q || cs_n)        state_d = IDLE;
        else if (state_q == RD_REQ) state_d = RD_WAIT;
        else                        state_d = WDATA;
      end else if (tcnt_q == 8'd1) begin
        req_d   = 1'b0;
        tcnt_d  = '0;
        err_d   = 1'b1;
        state_d = (abort_q || cs_n) ? IDLE : ERROR;
      end else begin
        tcnt_d = tcnt_q - 8'd1;
      end
    end else if (cs_n && state_q != IDLE) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          abort_d = 1'b0;
          if (cs_fall) begin
            state_d = CMD;
            err_d   = 1'b0;
          end
        end
        CMD: if (rx_valid) begin
          case (rx_byte)
            8'h02: begin is_wr_d = 1'b1; state_d = ADDR_HI; end
            8'h03: begin is_wr_d = 1'b0; state_d = ADDR_HI; end
`ifdef SPI_CMD_ID_EN
            8'h9F: begin
              tx_byte_d = ID_VALUE;
              tx_load_d = 1'b1;
              state_d   = ID_HOLD;
            end
`endif
            default: begin err_d = 1'b1; state_d = ERROR; end
          endcase
        end
        ADDR_HI: if (rx_valid) begin
          addr_d[15:8] = rx_byte;
          state_d      = ADDR_LO;
        end
        ADDR_LO: if (rx_valid) begin
          addr_d[7:0] = rx_byte;
          if (is_wr_q) begin
            state_d = WDATA;
          end else begin
            req_d   = 1'b1;
            we_d    = 1'b0;
            tcnt_d  = TCNT_LOAD;
            state_d = RD_REQ;
          end
        end
        WDATA: if (rx_valid) begin
          wdata_d = rx_byte;
          we_d    = 1'b1;
          req_d   = 1'b1;
          tcnt_d  = TCNT_LOAD;
          state_d = WR_REQ;
        end
        RD_WAIT: if (rx_valid) begin
          req_d   = 1'b1;
          we_d    = 1'b0;
          tcnt_d  = TCNT_LOAD;
          state_d = RD_REQ;
        end
`ifdef SPI_CMD_ID_EN
        ID_HOLD: if (rx_valid) begin
          tx_byte_d = ID_VALUE;
          tx_load_d = 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Directed self-checking bench for spi_cmd_sequencer (TIMEOUT overridden to 4).
module tb_spi_cmd_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cs_n = 1'b1;
  logic [7:0]  rx_byte = '0;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_byte;
  logic        tx_load;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        busy;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;

  spi_cmd_sequencer #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .tx_byte(tx_byte), .tx_load(tx_load), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic ack_cycle(input logic [7:0] rdata);
    mem_rdata = rdata;
    mem_ack   = 1'b1;
    @(negedge clk);
    mem_ack   = 1'b0;
  endtask

  task automatic frame_start();
    @(negedge clk);
    cs_n = 1'b0;
    @(negedge clk);
  endtask

  task automatic frame_end();
    cs_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    // reset values
    repeat (2) @(negedge clk);
    check("rst_req", {15'd0, mem_req}, 16'd0);
    check("rst_busy", {15'd0, busy}, 16'd0);
    check("rst_err", {15'd0, err}, 16'd0);
    check("rst_addr", mem_addr, 16'h0000);
    check("rst_tx", {7'd0, tx_load, tx_byte}, 16'd0);
    rst_n = 1'b1;

    // write 1234<-AA, 1235<-BB
    frame_start();
    check("wr_busy", {15'd0, busy}, 16'd1);
    send_byte(8'h02); send_byte(8'h12); send_byte(8'h34);
    check("wr_addr_cap", mem_addr, 16'h1234);
    check("wr_no_req", {15'd0, mem_req}, 16'd0);
    send_byte(8'hAA);
    check("wr1_req", {14'd0, mem_req, mem_we}, 16'h0003);
    check("wr1_addr", mem_addr, 16'h1234);
    check("wr1_data", {8'd0, mem_wdata}, 16'h00AA);
    ack_cycle(8'h00);
    check("wr1_done", {15'd0, mem_req}, 16'd0);
    check("wr1_inc", mem_addr, 16'h1235);
    send_byte(8'hBB);
    check("wr2_req", {14'd0, mem_req, mem_we}, 16'h0003);
    check("wr2_addr", mem_addr, 16'h1235);
    check("wr2_data", {8'd0, mem_wdata}, 16'h00BB);
    ack_cycle(8'h00);
    check("wr_err", {15'd0, err}, 16'd0);
    frame_end();
    check("wr_idle", {15'd0, busy}, 16'd0);

    // read with address wrap
    frame_start();
    send_byte(8'h03); send_byte(8'hFF); send_byte(8'hFF);
    check("rd1_req", {14'd0, mem_req, mem_we}, 16'h0002);
    check("rd1_addr", mem_addr, 16'hFFFF);
    ack_cycle(8'h11);
    check("rd1_load", {7'd0, tx_load, tx_byte}, 16'h0111);
    check("rd1_wrap", mem_addr, 16'h0000);
    check("rd1_req_off", {15'd0, mem_req}, 16'd0);
    @(negedge clk);
    check("rd1_pulse", {15'd0, tx_load}, 16'd0);
    send_byte(8'h00);
    check("rd2_req", {14'd0, mem_req, mem_we}, 16'h0002);
    check("rd2_addr", mem_addr, 16'h0000);
    ack_cycle(8'h22);
    check("rd2_load", {7'd0, tx_load, tx_byte}, 16'h0122);
    check("rd_err", {15'd0, err}, 16'd0);
    frame_end();

    // unknown command
    frame_start();
    send_byte(8'h55);
    check("unk_err", {15'd0, err}, 16'd1);
    send_byte(8'h02);
    check("unk_noreq_a", {15'd0, mem_req}, 16'd0);
    send_byte(8'h12);
    check("unk_noreq_b", {15'd0, mem_req}, 16'd0);
    send_byte(8'h34);
    send_byte(8'hAA);
    check("unk_noreq_c", {14'd0, busy, mem_req}, 16'h0002);
    frame_end();
    check("unk_sticky", {14'd0, busy, err}, 16'h0001);
    frame_start();
    check("unk_clear", {14'd0, busy, err}, 16'h0002);
    frame_end();

    // timeout with TIMEOUT=4
    frame_start();
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h10); send_byte(8'hAA);
    check("to_req_c1", {15'd0, mem_req}, 16'd1);
    for (int i = 2; i <= 4; i++) begin
      @(negedge clk);
      check("to_req_held", {15'd0, mem_req}, 16'd1);
    end
    @(negedge clk);
    check("to_drop", {14'd0, mem_req, err}, 16'h0001);
    check("to_error_state", {15'd0, busy}, 16'd1);
    ack_cycle(8'h00);
    check("to_late_ack", {13'd0, busy, mem_req, err}, 16'h0005);
    send_byte(8'h77);
    check("to_err_ignore", {14'd0, mem_req, tx_load}, 16'd0);
    frame_end();
    check("to_idle", {15'd0, busy}, 16'd0);

    // cs_n rises while a write request is outstanding
    frame_start();
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h20); send_byte(8'hCC);
    cs_n = 1'b1;
    @(negedge clk);
    check("ab_held", {14'd0, busy, mem_req}, 16'h0003);
    ack_cycle(8'h00);
    check("ab_idle", {13'd0, busy, mem_req, err}, 16'h0000);

    // read ack coinciding with cs_n rise
    frame_start();
    send_byte(8'h03); send_byte(8'h00); send_byte(8'h40);
    cs_n = 1'b1;
    ack_cycle(8'h5A);
    check("ackcs_load", {7'd0, tx_load, tx_byte}, 16'h015A);
    check("ackcs_idle", {14'd0, busy, mem_req}, 16'h0000);
    @(negedge clk);

    // ID command
    frame_start();
    send_byte(8'h9F);
`ifdef SPI_CMD_ID_EN
    check("id_load", {7'd0, tx_load, tx_byte}, 16'h01A5);
    check("id_err", {15'd0, err}, 16'd0);
    send_byte(8'h00);
    check("id_reload", {7'd0, tx_load, tx_byte}, 16'h01A5);
    check("id_nomem", {15'd0, mem_req}, 16'd0);
`else
    check("id_unknown", {15'd0, err}, 16'd1);
    check("id_noload", {15'd0, tx_load}, 16'd0);
`endif
    frame_end();

    // asynchronous reset during an outstanding read
    frame_start();
    send_byte(8'h03); send_byte(8'h00); send_byte(8'h50);
    check("ar_req", {15'd0, mem_req}, 16'd1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_drop", {14'd0, busy, mem_req}, 16'h0000);
    check("ar_addr", mem_addr, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    cs_n  = 1'b1;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
